// File: rtl/drt_enumerator_if.sv
// Wishbone read-master bus bundle between the DRT enumerator and the interconnect.
interface drt_enumerator_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_we_o,
        output wbm_sel_o,
        output wbm_adr_o,
        output wbm_dat_o,
        input  wbm_dat_i,
        input  wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_we_o,
        input  wbm_sel_o,
        input  wbm_adr_o,
        input  wbm_dat_o,
        output wbm_dat_i,
        output wbm_ack_i
    );
endinterface

// File: rtl/drt_enumerator.sv
// DRT enumerator: walks the device ROM table over wishbone, validates the
// header and searches the device entries for a requested device ID.
module drt_enumerator #(
    parameter logic [31:0] DRT_BASE_ADR    = 32'h0000_0000,
    parameter logic [15:0] EXPECTED_DRT_ID = 16'h0001,
    parameter int          MAX_DEVICES     = 16,
    parameter int          TIMEOUT_CYCLES  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       search_id,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [1:0]        err_code,
    output logic [15:0]       drt_version,
    output logic [31:0]       num_dev,
    output logic [7:0]        dev_index,
    output logic [31:0]       dev_mem_off,
    output logic [31:0]       dev_size,
    drt_enumerator_if.master  wb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_WAIT_REL,
        S_EVAL,
        S_FIN
    } state_t;

    typedef enum logic [2:0] {
        PH_HDR_ID,
        PH_HDR_NUM,
        PH_DEV_ID,
        PH_DEV_MEM,
        PH_DEV_SIZE
    } phase_t;

    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_DEV_W    = 32'(MAX_DEVICES);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_BAD_ID  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_COUNT   = 2'd3;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  timer_q, timer_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] search_q, search_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic [31:0] adr_q, adr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] ver_q, ver_d;
    logic [31:0] num_q, num_d;
    logic [7:0]  dev_index_q, dev_index_d;
    logic [31:0] mem_off_q, mem_off_d;
    logic [31:0] size_q, size_d;
    logic [7:0]  idx_next;

    // Word address of word 'word' inside device entry 'i'.
    function automatic logic [31:0] dev_adr(input logic [7:0] i, input logic [1:0] word);
        return DRT_BASE_ADR + 32'd4 + {22'd0, i, 2'b00} + {30'd0, word};
    endfunction

    // Next-state logic: sequences the header and entry reads and builds the results.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        rdata_d     = rdata_q;
        search_d    = search_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        adr_d       = adr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        err_d       = err_q;
        ver_d       = ver_q;
        num_d       = num_q;
        dev_index_d = dev_index_q;
        mem_off_d   = mem_off_q;
        size_d      = size_q;
        idx_next    = idx_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    search_d    = search_id;
                    found_d     = 1'b0;
                    err_d       = ERR_OK;
                    ver_d       = '0;
                    num_d       = '0;
                    dev_index_d = '0;
                    mem_off_d   = '0;
                    size_d      = '0;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    phase_d     = PH_HDR_ID;
                    adr_d       = DRT_BASE_ADR;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    state_d     = S_REQ;
                end
            end

            S_REQ: begin
                timer_d = '0;
                state_d = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (wb.wbm_ack_i) begin
                    rdata_d = wb.wbm_dat_i;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    timer_d = '0;
                    state_d = S_WAIT_REL;
                end else if (timer_q == TIMEOUT_LAST) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = ERR_TIMEOUT;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_WAIT_REL: begin
                if (!wb.wbm_ack_i) begin
                    state_d = S_EVAL;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_EVAL: begin
                case (phase_q)
                    PH_HDR_ID: begin
                        if (rdata_q[31:16] != EXPECTED_DRT_ID) begin
                            err_d   = ERR_BAD_ID;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            ver_d   = rdata_q[15:0];
                            phase_d = PH_HDR_NUM;
                            adr_d   = DRT_BASE_ADR + 32'd1;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            state_d = S_REQ;
                        end
                    end
                    PH_HDR_NUM: begin
                        num_d = rdata_q;
                        if (rdata_q > MAX_DEV_W) begin
                            err_d   = ERR_COUNT;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end else if (rdata_q == 32'd0) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            idx_d   = '0;
                            phase_d = PH_DEV_ID;
                            adr_d   = dev_adr(8'd0, 2'd0);
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            state_d = S_REQ;
                        end
                    end
                    PH_DEV_ID: begin
                        if (rdata_q[15:0] == search_q) begin
                            phase_d = PH_DEV_MEM;
                            adr_d   = dev_adr(idx_q, 2'd2);
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            state_d = S_REQ;
                        end else if ({24'd0, idx_next} == num_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            idx_d   = idx_next;
                            adr_d   = dev_adr(idx_next, 2'd0);
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            state_d = S_REQ;
                        end
                    end
                    PH_DEV_MEM: begin
                        mem_off_d = rdata_q;
                        phase_d   = PH_DEV_SIZE;
                        adr_d     = dev_adr(idx_q, 2'd3);
                        cyc_d     = 1'b1;
                        stb_d     = 1'b1;
                        state_d   = S_REQ;
                    end
                    PH_DEV_SIZE: begin
                        size_d      = rdata_q;
                        found_d     = 1'b1;
                        dev_index_d = idx_q;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_FIN;
                    end
                    default: begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                endcase
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_HDR_ID;
            idx_q       <= '0;
            timer_q     <= '0;
            rdata_q     <= '0;
            search_q    <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            err_q       <= ERR_OK;
            ver_q       <= '0;
            num_q       <= '0;
            dev_index_q <= '0;
            mem_off_q   <= '0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            rdata_q     <= rdata_d;
            search_q    <= search_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            adr_q       <= adr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            err_q       <= err_d;
            ver_q       <= ver_d;
            num_q       <= num_d;
            dev_index_q <= dev_index_d;
            mem_off_q   <= mem_off_d;
            size_q      <= size_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign err_code    = err_q;
    assign drt_version = ver_q;
    assign num_dev     = num_q;
    assign dev_index   = dev_index_q;
    assign dev_mem_off = mem_off_q;
    assign dev_size    = size_q;

    assign wb.wbm_cyc_o = cyc_q;
    assign wb.wbm_stb_o = stb_q;
    assign wb.wbm_we_o  = 1'b0;
    assign wb.wbm_sel_o = 4'hF;
    assign wb.wbm_adr_o = adr_q;
    assign wb.wbm_dat_o = 32'h0;

endmodule
